// File: rtl/alu_rs.sv
// alu_rs: 8-entry reservation station for ALU-class ops with dual-CDB wakeup and in-order-by-index dispatch.
// Optional feature: define ALU_RS_ISSUE_BYPASS_EN to capture a same-cycle CDB broadcast into issuing operands.
module alu_rs (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        flush,
   input  logic        issue_valid,
   input  logic [5:0]  issue_openum,
   input  logic [31:0] issue_V1,
   input  logic [31:0] issue_V2,
   input  logic        issue_R1,
   input  logic        issue_R2,
   input  logic [3:0]  issue_Q1,
   input  logic [3:0]  issue_Q2,
   input  logic [31:0] issue_imm,
   input  logic [31:0] issue_pc,
   input  logic [3:0]  issue_tag,
   output logic        rs_full,
   input  logic        cdb0_valid,
   input  logic [3:0]  cdb0_tag,
   input  logic [31:0] cdb0_value,
   input  logic        cdb1_valid,
   input  logic [3:0]  cdb1_tag,
   input  logic [31:0] cdb1_value,
   output logic [5:0]  alu_openum,
   output logic [31:0] alu_V1,
   output logic [31:0] alu_V2,
   output logic [31:0] alu_imm,
   output logic [31:0] alu_pc,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_target_pc,
   input  logic        alu_jump,
   input  logic        alu_valid,
   output logic        out_valid,
   output logic [3:0]  out_tag,
   output logic [31:0] out_result,
   output logic [31:0] out_pc,
   output logic        out_jump
);

   localparam int         N          = 8;
   localparam logic [5:0] OPENUM_NOP = 6'd0;

   logic [N-1:0] busy, r1, r2;
   logic [5:0]   openum [N];
   logic [31:0]  v1 [N], v2 [N], imm [N], pc [N];
   logic [3:0]   q1 [N], q2 [N], tag [N];

   logic         disp_valid;
   logic [3:0]   alu_tag;

   logic         free_found, disp_found;
   logic [2:0]   free_idx, disp_idx;
   logic [3:0]   free_cnt;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      disp_found = 1'b0;
      disp_idx   = '0;
      free_cnt   = '0;
      // Scan high to low so the last hit is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_found = 1'b1;
            free_idx   = i[2:0];
            free_cnt   = free_cnt + 4'd1;
         end
         if (busy[i] && r1[i] && r2[i]) begin
            disp_found = 1'b1;
            disp_idx   = i[2:0];
         end
      end
   end

   assign rs_full = (free_cnt < 4'd2);

   logic [31:0] in_v1, in_v2;
   logic        in_r1, in_r2;

   always_comb begin
      in_v1 = issue_V1;
      in_r1 = issue_R1;
      in_v2 = issue_V2;
      in_r2 = issue_R2;
`ifdef ALU_RS_ISSUE_BYPASS_EN
      // cdb0 is applied last so it wins when both buses carry the same tag.
      if (!issue_R1) begin
         if (cdb1_valid && cdb1_tag == issue_Q1) begin in_v1 = cdb1_value; in_r1 = 1'b1; end
         if (cdb0_valid && cdb0_tag == issue_Q1) begin in_v1 = cdb0_value; in_r1 = 1'b1; end
      end
      if (!issue_R2) begin
         if (cdb1_valid && cdb1_tag == issue_Q2) begin in_v2 = cdb1_value; in_r2 = 1'b1; end
         if (cdb0_valid && cdb0_tag == issue_Q2) begin in_v2 = cdb0_value; in_r2 = 1'b1; end
      end
`endif
   end

   // NOTE: entry payload has no reset; busy alone qualifies an entry, so stale payload is never observed.
   always_ff @(posedge clk) begin
      if (rdy) begin
         for (int i = 0; i < N; i++) begin
            if (busy[i] && !r1[i]) begin
               if (cdb0_valid && cdb0_tag == q1[i]) begin
                  v1[i] <= cdb0_value;
                  r1[i] <= 1'b1;
               end else if (cdb1_valid && cdb1_tag == q1[i]) begin
                  v1[i] <= cdb1_value;
                  r1[i] <= 1'b1;
               end
            end
            if (busy[i] && !r2[i]) begin
               if (cdb0_valid && cdb0_tag == q2[i]) begin
                  v2[i] <= cdb0_value;
                  r2[i] <= 1'b1;
               end else if (cdb1_valid && cdb1_tag == q2[i]) begin
                  v2[i] <= cdb1_value;
                  r2[i] <= 1'b1;
               end
            end
         end
         // The allocated slot was free before this edge, so it never collides with a wakeup above.
         if (issue_valid && !flush && free_found) begin
            openum[free_idx] <= issue_openum;
            v1[free_idx]     <= in_v1;
            v2[free_idx]     <= in_v2;
            r1[free_idx]     <= in_r1;
            r2[free_idx]     <= in_r2;
            q1[free_idx]     <= issue_Q1;
            q2[free_idx]     <= issue_Q2;
            imm[free_idx]    <= issue_imm;
            pc[free_idx]     <= issue_pc;
            tag[free_idx]    <= issue_tag;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy       <= '0;
         alu_openum <= OPENUM_NOP;
         alu_V1     <= '0;
         alu_V2     <= '0;
         alu_imm    <= '0;
         alu_pc     <= '0;
         alu_tag    <= '0;
         disp_valid <= 1'b0;
         out_valid  <= 1'b0;
         out_tag    <= '0;
         out_result <= '0;
         out_pc     <= '0;
         out_jump   <= 1'b0;
      end else if (rdy) begin
         if (flush) begin
            busy       <= '0;
            alu_openum <= OPENUM_NOP;
            disp_valid <= 1'b0;
            out_valid  <= 1'b0;
         end else begin
            out_valid  <= disp_valid & alu_valid;
            out_tag    <= alu_tag;
            out_result <= alu_result;
            out_pc     <= alu_target_pc;
            out_jump   <= alu_jump;
            if (disp_found) begin
               busy[disp_idx] <= 1'b0;
               alu_openum     <= openum[disp_idx];
               alu_V1         <= v1[disp_idx];
               alu_V2         <= v2[disp_idx];
               alu_imm        <= imm[disp_idx];
               alu_pc         <= pc[disp_idx];
               alu_tag        <= tag[disp_idx];
               disp_valid     <= 1'b1;
            end else begin
               alu_openum <= OPENUM_NOP;
               disp_valid <= 1'b0;
            end
            if (issue_valid && free_found) busy[free_idx] <= 1'b1;
         end
      end
   end

endmodule
